// File: rtl/chip8_sprite_writer_if.sv
// Memory bus between the sprite writer and the shared 4 KiB memory.
// Reads are synchronous: mem_rdata reflects the address presented on the previous cycle.
interface chip8_sprite_writer_if;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/chip8_sprite_writer.sv
// CHIP-8 framebuffer writer: DXYN sprite draw (XOR with collision) and 00E0 clear.
// Every VRAM update is a read-modify-write through a 1-cycle synchronous memory.
module chip8_sprite_writer #(
    parameter logic [11:0] VRAM_BASE = 12'hF00
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          draw_start,
    input  logic                          clear_start,
    input  logic [7:0]                    draw_x,
    input  logic [7:0]                    draw_y,
    input  logic [3:0]                    draw_n,
    input  logic [11:0]                   sprite_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          collision,
    chip8_sprite_writer_if.master         mem
);

    typedef enum logic [2:0] {
        IDLE,
        SPR_RD,
        SPR_LATCH,
        L_WR,
        R_RD,
        R_WR,
        CLR,
        DONE
    } state_t;

    state_t      state, state_nxt;

    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [3:0]  n_q;
    logic [11:0] i_q;
    logic [3:0]  row;
    logic [7:0]  cnt;
    logic [15:0] spr;

    logic [2:0]  shift;
    logic [4:0]  yr;
    logic [2:0]  col_l;
    logic [2:0]  col_r;
    logic [11:0] l_addr;
    logic [11:0] r_addr;
    logic        last_row;
    logic        accept;

    // Byte address of framebuffer row/column; 8 bytes per 64-pixel row.
    function automatic logic [11:0] vram_addr(input logic [4:0] vrow, input logic [2:0] vcol);
        return VRAM_BASE + {4'h0, vrow, vcol};
    endfunction

    assign shift    = x_q[2:0];
    assign yr       = y_q + {1'b0, row};
    assign col_l    = x_q[5:3];
    assign col_r    = col_l + 3'd1;
    assign l_addr   = vram_addr(yr, col_l);
    assign r_addr   = vram_addr(yr, col_r);
    assign last_row = (row == n_q - 4'd1);
    assign accept   = (state == IDLE) && (draw_start || clear_start);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and bus outputs; idle and done keep the bus quiet.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 12'h000;
        mem.mem_wdata = 8'h00;
        case (state)
            IDLE: begin
                if (clear_start)     state_nxt = CLR;
                else if (draw_start) state_nxt = (draw_n == 4'd0) ? DONE : SPR_RD;
            end
            SPR_RD: begin
                busy         = 1'b1;
                mem.mem_addr = i_q + {8'h00, row};
                state_nxt    = SPR_LATCH;
            end
            SPR_LATCH: begin
                busy         = 1'b1;
                mem.mem_addr = l_addr;
                state_nxt    = L_WR;
            end
            L_WR: begin
                busy          = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = l_addr;
                mem.mem_wdata = mem.mem_rdata ^ spr[15:8];
                if (shift != 3'd0) state_nxt = R_RD;
                else               state_nxt = last_row ? DONE : SPR_RD;
            end
            R_RD: begin
                busy         = 1'b1;
                mem.mem_addr = r_addr;
                state_nxt    = R_WR;
            end
            R_WR: begin
                busy          = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = r_addr;
                mem.mem_wdata = mem.mem_rdata ^ spr[7:0];
                state_nxt     = last_row ? DONE : SPR_RD;
            end
            CLR: begin
                busy         = 1'b1;
                mem.mem_we   = 1'b1;
                mem.mem_addr = vram_addr(cnt[7:3], cnt[2:0]);
                if (cnt == 8'hFF) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control counters and the collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
            row       <= 4'd0;
            cnt       <= 8'd0;
        end else begin
            if (accept) begin
                collision <= 1'b0;
                row       <= 4'd0;
                cnt       <= 8'd0;
            end else begin
                if (state == L_WR)
                    collision <= collision | (|(mem.mem_rdata & spr[15:8]));
                else if (state == R_WR)
                    collision <= collision | (|(mem.mem_rdata & spr[7:0]));
                if ((state == L_WR && shift == 3'd0) || state == R_WR)
                    row <= row + 4'd1;
                if (state == CLR)
                    cnt <= cnt + 8'd1;
            end
        end
    end

    // Draw operands latched on accept; sprite byte pre-shifted across two bytes.
    always_ff @(posedge clk) begin
        if (state == IDLE && draw_start) begin
            x_q <= 6'(draw_x);
            y_q <= 5'(draw_y);
            n_q <= draw_n;
            i_q <= sprite_addr;
        end
        if (state == SPR_LATCH)
            spr <= {mem.mem_rdata, 8'h00} >> shift;
    end

endmodule

// File: tb/tb_chip8_sprite_writer.sv
// Directed bench for chip8_sprite_writer with a 4 KiB synchronous memory model.
module tb_chip8_sprite_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        draw_start = 1'b0;
    logic        clear_start = 1'b0;
    logic [7:0]  draw_x = 8'd0;
    logic [7:0]  draw_y = 8'd0;
    logic [3:0]  draw_n = 4'd0;
    logic [11:0] sprite_addr = 12'd0;
    logic        busy, done, collision;

    logic        tb_we = 1'b0;
    logic [11:0] tb_addr = 12'd0;
    logic [7:0]  tb_wdata = 8'd0;
    logic [7:0]  mem [4096];
    int          wr_total = 0;

    int total = 0;
    int bad   = 0;

    chip8_sprite_writer_if bus ();

    chip8_sprite_writer #(.VRAM_BASE(12'hF00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .draw_start  (draw_start),
        .clear_start (clear_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_n      (draw_n),
        .sprite_addr (sprite_addr),
        .busy        (busy),
        .done        (done),
        .collision   (collision),
        .mem         (bus.master)
    );

    always #5 clk = ~clk;

    // Memory model: bench preload port has priority, read data one cycle late.
    always @(posedge clk) begin
        if (tb_we)           mem[tb_addr] <= tb_wdata;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Count every DUT write that commits.
    always @(posedge clk) begin
        if (bus.mem_we) wr_total <= wr_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic set_draw(input logic [7:0] x, input logic [7:0] y,
                            input logic [3:0] n, input logic [11:0] i);
        draw_x = x; draw_y = y; draw_n = n; sprite_addr = i;
    endtask

    // Pulse a start, return the cycle (accept = 0) at which done is seen.
    // With chkseq set, each busy cycle must be the next clear write.
    task automatic run_op(input bit d, input bit c, input bit chkseq,
                          output int cyc, output int seq_err);
        @(negedge clk);
        draw_start = d; clear_start = c;
        @(negedge clk);
        draw_start = 1'b0; clear_start = 1'b0;
        cyc = 1;
        seq_err = 0;
        while (!done && cyc < 400) begin
            if (chkseq && (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'(12'hF00 + cyc - 1) ||
                           bus.mem_wdata !== 8'h00))
                seq_err++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int cyc, serr, w0, nz;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_coll", collision, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 12'h000);
        chk("rst_wdata", bus.mem_wdata, 8'h00);
        rst_n = 1'b1;

        // Clear over a VRAM full of 0xAA
        for (int a = 0; a < 256; a++) poke(12'(12'hF00 + a), 8'hAA);
        w0 = wr_total;
        run_op(1'b0, 1'b1, 1'b1, cyc, serr);
        chk("clr_cycle", cyc, 257);
        chk("clr_writes", wr_total - w0, 256);
        chk("clr_seq", serr, 0);
        chk("clr_coll", collision, 1'b0);
        nz = 0;
        for (int a = 0; a < 256; a++) if (mem[12'(12'hF00 + a)] !== 8'h00) nz++;
        chk("clr_zero", nz, 0);

        // Aligned draw then redraw
        poke(12'h200, 8'hF0);
        set_draw(8'd8, 8'd0, 4'd1, 12'h200);
        w0 = wr_total;
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("al_cycle", cyc, 4);
        chk("al_writes", wr_total - w0, 1);
        chk("al_F01", mem[12'hF01], 8'hF0);
        chk("al_coll", collision, 1'b0);
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("al2_F01", mem[12'hF01], 8'h00);
        chk("al2_coll", collision, 1'b1);

        // Unaligned, vertical wrap
        poke(12'h300, 8'hFF);
        poke(12'h301, 8'h81);
        set_draw(8'd4, 8'd31, 4'd2, 12'h300);
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("ua_cycle", cyc, 11);
        chk("ua_FF8", mem[12'hFF8], 8'h0F);
        chk("ua_FF9", mem[12'hFF9], 8'hF0);
        chk("ua_F00", mem[12'hF00], 8'h08);
        chk("ua_F01", mem[12'hF01], 8'h10);
        chk("ua_coll", collision, 1'b0);

        // Horizontal wrap on a fresh screen
        run_op(1'b0, 1'b1, 1'b0, cyc, serr);
        poke(12'h310, 8'hFF);
        set_draw(8'd60, 8'd0, 4'd1, 12'h310);
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("hw_cycle", cyc, 6);
        chk("hw_F07", mem[12'hF07], 8'h0F);
        chk("hw_F00", mem[12'hF00], 8'hF0);

        // Coordinate modulo: (200,40) lands at (8,8)
        set_draw(8'd200, 8'd40, 4'd1, 12'h310);
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("mod_cycle", cyc, 4);
        chk("mod_F41", mem[12'hF41], 8'hFF);
        chk("mod_coll", collision, 1'b0);
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("mod2_F41", mem[12'hF41], 8'h00);
        chk("mod2_coll", collision, 1'b1);

        // n = 0: immediate done, no writes, collision cleared
        set_draw(8'd0, 8'd0, 4'd0, 12'h310);
        w0 = wr_total;
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("n0_cycle", cyc, 1);
        chk("n0_writes", wr_total - w0, 0);
        chk("n0_coll", collision, 1'b0);

        // Draw and clear together: clear wins
        set_draw(8'd0, 8'd0, 4'd1, 12'h310);
        w0 = wr_total;
        run_op(1'b1, 1'b1, 1'b1, cyc, serr);
        chk("both_cycle", cyc, 257);
        chk("both_seq", serr, 0);
        chk("both_writes", wr_total - w0, 256);
        chk("both_F07", mem[12'hF07], 8'h00);

        // Start while busy is ignored
        w0 = wr_total;
        @(negedge clk);
        draw_start = 1'b1;
        @(negedge clk);
        draw_start = 1'b0;
        chk("bz_busy", busy, 1'b1);
        @(negedge clk);
        draw_x = 8'd16; draw_start = 1'b1;
        @(negedge clk);
        draw_start = 1'b0;
        @(negedge clk);
        chk("bz_done", done, 1'b1);
        repeat (3) @(negedge clk);
        chk("bz_idle", busy, 1'b0);
        chk("bz_writes", wr_total - w0, 1);
        chk("bz_F00", mem[12'hF00], 8'hFF);
        chk("bz_F02", mem[12'hF02], 8'h00);

        // Reset during R_RD of a draw
        run_op(1'b0, 1'b1, 1'b0, cyc, serr);
        set_draw(8'd4, 8'd0, 4'd2, 12'h300);
        @(negedge clk);
        draw_start = 1'b1;
        @(negedge clk);
        draw_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_addr", bus.mem_addr, 12'hF01);
        chk("rr_we", bus.mem_we, 1'b0);
        w0 = wr_total;
        rst_n = 1'b0;
        #1;
        chk("rr_busy", busy, 1'b0);
        chk("rr_oaddr", bus.mem_addr, 12'h000);
        chk("rr_done", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("rr_nowr", wr_total - w0, 0);
        chk("rr_F00", mem[12'hF00], 8'h0F);
        chk("rr_F01", mem[12'hF01], 8'h00);
        rst_n = 1'b1;
        run_op(1'b1, 1'b0, 1'b0, cyc, serr);
        chk("ra_cycle", cyc, 11);
        chk("ra_F00", mem[12'hF00], 8'h00);
        chk("ra_F01", mem[12'hF01], 8'hF0);
        chk("ra_F08", mem[12'hF08], 8'h08);
        chk("ra_F09", mem[12'hF09], 8'h10);
        chk("ra_coll", collision, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
